div32_seq: RTL and testbench

//  Iterative signed radix-2 restoring divider; the inverse operation of the Booth

---
 rtl/div32_seq.sv | 118 +++++++++++
 tb/tb_div32_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// Iterative signed radix-2 restoring divider.
// One quotient bit per clock; done pulses W+1 edges after the start edge.
//
// state | meaning
// IDLE  | waiting for start; results from the last division held
// CALC  | W restoring iterations, one quotient bit per edge
// FIXUP | apply signs and special cases, pulse done
module div32_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         div_by_zero,
  output logic         ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  localparam int CW = $clog2(W);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  qreg;
  logic [W:0]    acc;
  logic [W:0]    dvs;
  logic          sign_a, sign_b, dz, ov;

  logic [W:0]    acc_sh;
  logic [W:0]    acc_diff;
  logic          acc_ge;
  logic          last_iter;

  // Shifted partial remainder and the trial subtraction against |divisor|.
  // acc stays below |divisor| <= 2^(W-1), so the shift never loses a bit.
  assign acc_sh    = {acc[W-1:0], qreg[W-1]};
  assign acc_diff  = acc_sh - dvs;
  assign acc_ge    = (acc_sh >= dvs);
  assign last_iter = (cnt == CW'(W - 1));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      qreg        <= '0;
      acc         <= '0;
      dvs         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // |-2^(W-1)| is 2^(W-1), which still fits W unsigned bits.
            qreg   <= dividend[W-1] ? -dividend : dividend;
            dvs    <= divisor[W-1] ? -{divisor[W-1], divisor} : {1'b0, divisor};
            sign_a <= dividend[W-1];
            sign_b <= divisor[W-1];
            dz     <= (divisor == '0);
            ov     <= (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc  <= acc_ge ? acc_diff : acc_sh;
          qreg <= {qreg[W-2:0], acc_ge};
          cnt  <= cnt + CW'(1);
        end
        FIXUP: begin
          // With a zero divisor every trial succeeds, so acc ends up holding
          // |dividend| and the signed remainder naturally equals the dividend;
          // only the quotient needs forcing. The overflow case wraps to
          // -2^(W-1) by itself.
          q           <= dz ? '1 : ((sign_a ^ sign_b) ? -qreg : qreg);
          r           <= sign_a ? W'(-acc) : W'(acc);
          div_by_zero <= dz;
          ovf         <= ov;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed + random bench for div32_seq with an expected-result queue.
module tb_div32_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero, ovf;
  logic [31:0] q, r;

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];

  div32_seq #(.W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .q(q), .r(r),
    .div_by_zero(div_by_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb_;
    sa = a; sb_ = b;
    e.a = a; e.b = b; e.dz = 1'b0; e.ov = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.ov = 1'b1;
    end else begin
      e.q = sa / sb_;
      e.r = sa % sb_;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for done, then check latency and pop/compare the result.
  task automatic check_result(input int e0);
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (done === 1'b1) begin
        chk($sformatf("latency %h/%h", e.a, e.b), cyc - e0, 32'd33);
        chk($sformatf("q %h/%h", e.a, e.b), q, e.q);
        chk($sformatf("r %h/%h", e.a, e.b), r, e.r);
        chk($sformatf("dz %h/%h", e.a, e.b), {31'd0, div_by_zero}, {31'd0, e.dz});
        chk($sformatf("ovf %h/%h", e.a, e.b), {31'd0, ovf}, {31'd0, e.ov});
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input bit full);
    int e0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    if (full) chk("busy_after_start", {31'd0, busy}, 32'd1);
    check_result(e0);
    @(negedge clk);
    if (full) chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int e0, e1;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    // Basic, signs, divide by zero, overflow.
    run_one(32'd100, 32'd7, 1'b1);
    chk("t1_q_const", q, 32'd14);
    chk("t1_r_const", r, 32'd2);
    run_one(-32'sd100, 32'd7, 1'b1);
    chk("t2a_q_const", q, -32'sd14);
    run_one(32'd100, -32'sd7, 1'b1);
    run_one(-32'sd100, -32'sd7, 1'b1);
    chk("t2c_r_const", r, -32'sd2);
    run_one(32'h1234_5678, 32'd0, 1'b1);
    run_one(32'h8765_4321, 32'd0, 1'b1);
    run_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_one(32'h8000_0000, 32'd2, 1'b1);
    chk("t4b_q_const", q, 32'hC000_0000);
    run_one(32'h8000_0000, 32'h8000_0000, 1'b1);
    run_one(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    run_one(32'h7FFF_FFFF, 32'd1, 1'b1);
    run_one(32'd5, 32'd100, 1'b1);

    // Back-to-back with start held high; operand changes while busy ignored.
    @(negedge clk);
    dividend = 32'd1000; divisor = -32'sd3; start = 1'b1;
    sb.push_back(model(32'd1000, -32'sd3));
    @(negedge clk);
    e0 = cyc;
    dividend = 32'd77; divisor = 32'd1;
    check_result(e0);
    dividend = 32'd0; divisor = 32'd5;
    sb.push_back(model(32'd0, 32'd5));
    @(negedge clk);
    e1 = cyc;
    chk("b2b_throughput", e1 - e0, 32'd34);
    chk("b2b_done_dropped", {31'd0, done}, 32'd0);
    dividend = 32'hDEAD_BEEF; divisor = 32'd3;
    check_result(e1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done_end", {31'd0, done}, 32'd0);

    // Reset mid-division aborts it.
    run_one(32'd5, 32'd1, 1'b0);
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", q, 32'd0);
    chk("abort_r", r, 32'd0);
    chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done === 1'b1) seen++;
      end
      chk("abort_no_done", seen, 32'd0);
    end
    run_one(32'd1000, 32'd7, 1'b1);

    // Random signed operands with varied magnitudes.
    for (int i = 0; i < 1200; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = $signed(a) >>> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 0) b = $signed(b) >>> $urandom_range(0, 31);
      case ($urandom_range(0, 40))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_one(a, b, 1'b0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
